// File: rtl/test_pattern_gen.sv
// Synthetic sensor-side video source: programmable frame/line timing with four
// selectable pixel patterns. All outputs are registered, one clock behind the FSM.
module test_pattern_gen #(
    parameter int SENSOR_DAT_WIDTH = 10,
    parameter int CHANNEL_NUM      = 4,
    parameter int REG_WD           = 32
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   i_enable,
    input  logic [1:0]                             iv_pattern_sel,
    input  logic [SENSOR_DAT_WIDTH-1:0]            iv_grey_value,
    input  logic [15:0]                            iv_line_active,
    input  logic [15:0]                            iv_line_blank,
    input  logic [15:0]                            iv_frame_lines,
    input  logic [15:0]                            iv_frame_blank,
    output logic                                   o_fval,
    output logic                                   o_lval,
    output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
    output logic [REG_WD-1:0]                      ov_frame_cnt
);

    localparam int SDW = SENSOR_DAT_WIDTH;
    localparam int PW  = SENSOR_DAT_WIDTH * CHANNEL_NUM;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEAD   = 3'd1,
        S_LINE   = 3'd2,
        S_HBLANK = 3'd3,
        S_VBLANK = 3'd4
    } state_t;

    state_t            r_state;
    logic [15:0]       r_cnt;
    logic [15:0]       r_line;
    logic [15:0]       r_w;
    logic [15:0]       r_h;
    logic [15:0]       r_l;
    logic [15:0]       r_v;
    logic [1:0]        r_pat;
    logic [SDW-1:0]    r_grey;
    logic [SDW-1:0]    r_fc_pix;
    logic              r_fval;
    logic              r_lval;
    logic [PW-1:0]     r_pix;
    logic [REG_WD-1:0] r_frame_cnt;

    logic [15:0]       w_len;
    logic              w_last;
    logic              w_in_frame;
    logic              w_frame_end;
    logic              w_latch;
    logic [REG_WD-1:0] w_frame_cnt_nxt;
    logic [PW-1:0]     w_pix;

    function automatic logic [15:0] f_nz(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

    // Length of the current state's dwell, in clocks
    always_comb begin
        w_len = 16'd1;
        case (r_state)
            S_LEAD:   w_len = r_h;
            S_LINE:   w_len = r_w;
            S_HBLANK: w_len = r_h;
            S_VBLANK: w_len = r_v;
            default:  w_len = 16'd1;
        endcase
    end

    assign w_last          = (r_cnt == (w_len - 16'd1));
    assign w_in_frame      = (r_state == S_LEAD) || (r_state == S_LINE) || (r_state == S_HBLANK);
    // fval is still high on the first VBLANK clock; that is the edge where it falls
    assign w_frame_end     = r_fval && (r_state == S_VBLANK);
    assign w_frame_cnt_nxt = w_frame_end ? (r_frame_cnt + REG_WD'(1'b1)) : r_frame_cnt;
    assign w_latch         = i_enable && ((r_state == S_IDLE) || ((r_state == S_VBLANK) && w_last));

    // Pixel value for every channel at the current line position
    always_comb begin
        w_pix = {PW{1'b0}};
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            case (r_pat)
                2'd0:    w_pix[c*SDW +: SDW] = r_grey;
                2'd1:    w_pix[c*SDW +: SDW] = SDW'(32'(r_cnt) * 32'(CHANNEL_NUM) + 32'(c));
                2'd2:    w_pix[c*SDW +: SDW] = SDW'(r_line);
                2'd3:    w_pix[c*SDW +: SDW] = r_fc_pix;
                default: w_pix[c*SDW +: SDW] = r_grey;
            endcase
        end
    end

    // Frame configuration, captured only at the start of a frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_w      <= 16'd0;
            r_h      <= 16'd0;
            r_l      <= 16'd0;
            r_v      <= 16'd0;
            r_pat    <= 2'd0;
            r_grey   <= {SDW{1'b0}};
            r_fc_pix <= {SDW{1'b0}};
        end else if (w_latch) begin
            r_w      <= f_nz(iv_line_active);
            r_h      <= f_nz(iv_line_blank);
            r_l      <= f_nz(iv_frame_lines);
            r_v      <= f_nz(iv_frame_blank);
            r_pat    <= iv_pattern_sel;
            r_grey   <= iv_grey_value;
            r_fc_pix <= SDW'(w_frame_cnt_nxt);
        end
    end

    // Timing FSM, counters and registered video outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_line      <= 16'd0;
            r_fval      <= 1'b0;
            r_lval      <= 1'b0;
            r_pix       <= {PW{1'b0}};
            r_frame_cnt <= {REG_WD{1'b0}};
        end else begin
            r_fval      <= w_in_frame;
            r_lval      <= (r_state == S_LINE);
            r_pix       <= (r_state == S_LINE) ? w_pix : {PW{1'b0}};
            r_frame_cnt <= w_frame_cnt_nxt;

            if ((r_state == S_IDLE) || w_last) begin
                r_cnt <= 16'd0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            case (r_state)
                S_IDLE: begin
                    r_line <= 16'd0;
                    if (w_latch) begin
                        r_state <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (w_last) begin
                        r_state <= S_LINE;
                    end
                end
                S_LINE: begin
                    if (w_last) begin
                        r_state <= S_HBLANK;
                    end
                end
                S_HBLANK: begin
                    if (w_last) begin
                        if (r_line == (r_l - 16'd1)) begin
                            r_line  <= 16'd0;
                            r_state <= S_VBLANK;
                        end else begin
                            r_line  <= r_line + 16'd1;
                            r_state <= S_LINE;
                        end
                    end
                end
                S_VBLANK: begin
                    if (w_last) begin
                        r_state <= i_enable ? S_LEAD : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_line  <= 16'd0;
                end
            endcase
        end
    end

    assign o_fval       = r_fval;
    assign o_lval       = r_lval;
    assign ov_pix_data  = r_pix;
    assign ov_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Self-checking bench for test_pattern_gen: directed and randomized frames compared
// cycle by cycle against an arithmetic model of frame timing and pixel content.
module tb_test_pattern_gen;

    localparam int SDW = 10;
    localparam int CH  = 4;
    localparam int RW  = 32;
    localparam int PW  = SDW * CH;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_enable;
    logic [1:0]    iv_pattern_sel;
    logic [SDW-1:0] iv_grey_value;
    logic [15:0]   iv_line_active;
    logic [15:0]   iv_line_blank;
    logic [15:0]   iv_frame_lines;
    logic [15:0]   iv_frame_blank;
    logic          o_fval;
    logic          o_lval;
    logic [PW-1:0] ov_pix_data;
    logic [RW-1:0] ov_frame_cnt;

    always #5 clk = ~clk;

    test_pattern_gen #(.SENSOR_DAT_WIDTH(SDW), .CHANNEL_NUM(CH), .REG_WD(RW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_enable       (i_enable),
        .iv_pattern_sel (iv_pattern_sel),
        .iv_grey_value  (iv_grey_value),
        .iv_line_active (iv_line_active),
        .iv_line_blank  (iv_line_blank),
        .iv_frame_lines (iv_frame_lines),
        .iv_frame_blank (iv_frame_blank),
        .o_fval         (o_fval),
        .o_lval         (o_lval),
        .ov_pix_data    (ov_pix_data),
        .ov_frame_cnt   (ov_frame_cnt)
    );

    int npass = 0;
    int ntot  = 0;
    int nfail = 0;

    // configuration of the frame under check (c*) and the one queued on the inputs (n*)
    int cw, chb, cl, cv, cpat, cgrey;
    int nw, nh, nl, nv, npat, ngrey;
    logic nen;
    logic [31:0] exp_fc;
    longint gsum;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    task automatic set_next(input int w, input int h, input int l, input int v,
                            input int pat, input int grey, input logic en);
        nw = w; nh = h; nl = l; nv = v; npat = pat; ngrey = grey; nen = en;
    endtask

    task automatic rand_next(input logic en);
        set_next(int'($urandom_range(12, 0)), int'($urandom_range(4, 0)),
                 int'($urandom_range(4, 0)), int'($urandom_range(4, 0)),
                 int'($urandom_range(3, 0)), int'($urandom_range(1023, 0)), en);
    endtask

    task automatic drive_next();
        i_enable       = nen;
        iv_line_active = 16'(nw);
        iv_line_blank  = 16'(nh);
        iv_frame_lines = 16'(nl);
        iv_frame_blank = 16'(nv);
        iv_pattern_sel = 2'(npat);
        iv_grey_value  = SDW'(ngrey);
    endtask

    task automatic take_next();
        cw = nw; chb = nh; cl = nl; cv = nv; cpat = npat; cgrey = ngrey;
    endtask

    // bounded wait for o_fval to rise, checking the number of clocks it took
    task automatic wait_rise(input int expect_n);
        int n;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (o_fval) break;
        end
        chk("fval_rise_delay", 64'(n), 64'(expect_n));
    endtask

    // check one whole frame period starting at the sample where o_fval is first high;
    // the queued configuration is driven onto the inputs at sample mid_t
    task automatic check_frame(input int mid_t);
        int w, h, l, v, fh, p, u, pos, m;
        logic [31:0] fc0;
        logic [PW-1:0] ep;
        logic ef, el;
        w = eff(cw); h = eff(chb); l = eff(cl); v = eff(cv);
        fh  = h + l * (w + h);
        p   = fh + v;
        fc0 = exp_fc;
        if (mid_t < 0 || mid_t > p - 2) mid_t = int'($urandom_range(p - 2, 0));
        for (int t = 0; t < p; t++) begin
            if (t > 0) @(negedge clk);
            ef = (t < fh);
            el = 1'b0;
            ep = '0;
            if (t >= h && t < fh) begin
                u   = t - h;
                pos = u % (w + h);
                if (pos < w) begin
                    el = 1'b1;
                    for (int c = 0; c < CH; c++) begin
                        case (cpat)
                            0:       m = cgrey;
                            1:       m = pos * CH + c;
                            2:       m = u / (w + h);
                            default: m = int'(fc0);
                        endcase
                        ep[c*SDW +: SDW] = SDW'(m);
                    end
                end
            end
            chk("fval", 64'(o_fval), 64'(ef));
            chk("lval", 64'(o_lval), 64'(el));
            chk("pix_data", 64'(ov_pix_data), 64'(ep));
            chk("frame_cnt", 64'(ov_frame_cnt), 64'(ef ? fc0 : fc0 + 32'd1));
            if (o_lval) begin
                for (int c = 0; c < CH; c++) gsum += longint'(ov_pix_data[c*SDW+2 +: 8]);
            end
            if (t == mid_t) drive_next();
        end
        exp_fc = fc0 + 32'd1;
        if (nen) take_next();
    endtask

    task automatic check_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("idle_fval", 64'(o_fval), 64'd0);
            chk("idle_frame_cnt", 64'(ov_frame_cnt), 64'(exp_fc));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        set_next(0, 0, 0, 0, 0, 0, 1'b0);
        drive_next();
        exp_fc = 32'd0;
        gsum   = 0;
        repeat (2) @(negedge clk);
        chk("reset_fval", 64'(o_fval), 64'd0);
        chk("reset_lval", 64'(o_lval), 64'd0);
        chk("reset_pix", 64'(ov_pix_data), 64'd0);
        chk("reset_frame_cnt", 64'(ov_frame_cnt), 64'd0);
        reset_n = 1'b1;

        // basic timing, three continuous frames, then W change mid-line
        set_next(4, 2, 3, 5, 1, 0, 1'b1);
        drive_next();
        take_next();
        wait_rise(2);
        check_frame(10);
        wait_rise(1);
        check_frame(10);
        set_next(8, 2, 3, 5, 1, 0, 1'b1);
        wait_rise(1);
        check_frame(9);
        set_next(4, 2, 3, 5, 0, 'h3FC, 1'b1);
        wait_rise(1);
        check_frame(15);
        set_next(4, 2, 3, 5, 2, 0, 1'b1);
        wait_rise(1);
        gsum = 0;
        check_frame(12);
        chk("grey_sum", 64'(gsum), 64'd12240);
        // enable dropped during line 2 of 3
        set_next(4, 2, 3, 5, 3, 0, 1'b0);
        wait_rise(1);
        check_frame(9);
        check_idle(20);

        // long line: horizontal ramp wraps at pixel 1024
        set_next(300, 2, 1, 3, 1, 0, 1'b1);
        drive_next();
        take_next();
        nen = 1'b0;
        wait_rise(2);
        check_frame(0);
        check_idle(10);

        // randomized continuous frames, configuration changed somewhere in each frame
        rand_next(1'b1);
        drive_next();
        take_next();
        wait_rise(2);
        for (int i = 0; i < 8; i++) begin
            rand_next(i != 7);
            check_frame(-1);
            if (i != 7) wait_rise(1);
        end
        check_idle(10);

        // asynchronous reset in the middle of a line
        set_next(4, 2, 3, 5, 1, 0, 1'b1);
        drive_next();
        take_next();
        wait_rise(2);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async_rst_fval", 64'(o_fval), 64'd0);
        chk("async_rst_lval", 64'(o_lval), 64'd0);
        chk("async_rst_pix", 64'(ov_pix_data), 64'd0);
        chk("async_rst_frame_cnt", 64'(ov_frame_cnt), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_fc  = 32'd0;
        set_next(4, 2, 3, 5, 1, 0, 1'b0);
        wait_rise(2);
        check_frame(5);
        check_idle(5);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
